fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller for the experiment CPU. Owns the program counter and issues one request at a time to the instruction memory. Captures each returned instruction and hands it to decode with a valid/ready handshake. Supports branch redirect and a halt opcode that stops fetching.

Parameters:
PC_WIDTH, 8, program counter / instruction address width
INST_WIDTH, 32, instruction word width
RESET_PC, 0, PC value after reset
HALT_OPCODE, 6'b111111, value of inst[31:26] that marks a halt instruction
COUNT_WIDTH, 16, width of delivered-instruction counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin fetching (sampled in IDLE only)
redirect_valid  in  1  load new PC (branch/jump)
redirect_pc  in  PC_WIDTH  redirect target
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_WIDTH  fetch address
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  INST_WIDTH  read data
inst_valid  out  1  instruction available to decode
inst  out  INST_WIDTH  captured instruction
inst_pc  out  PC_WIDTH  address of captured instruction
inst_ready  in  1  decode accepts instruction
pc  out  PC_WIDTH  current fetch PC
halted  out  1  halt instruction consumed, fetching stopped
inst_count  out  COUNT_WIDTH  instructions accepted by decode

Behaviour:
- Reset (async, any state, mid-transaction included): state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, halted=0, inst_count=0, discard=0. imem_req=0.
- States: IDLE, REQ, WAIT, HOLD, HALT. All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- IDLE: start=1 -> REQ. redirect_valid loads pc and stays in IDLE.
- REQ: imem_req=1, imem_addr=pc. The address may change while not granted, only via redirect. If imem_gnt=1 -> WAIT, latch req_pc=pc.
- WAIT: imem_req=0. On imem_rvalid:
  - if discard=1: drop the data, clear discard, -> REQ.
  - otherwise: inst<=imem_rdata, inst_pc<=req_pc, pc<=req_pc+1 (mod 2^PC_WIDTH; 255 wraps to 0), inst_valid<=1, -> HOLD.
- HOLD: inst_valid=1, and inst/inst_pc are held stable until the handshake. When inst_valid&inst_ready:
  - inst_count+1 (wraps).
  - inst_valid<=0.
  - if inst[31:26]==HALT_OPCODE -> HALT, else -> REQ.
- HALT: halted=1, no requests. Only rst exits. start and redirect are ignored.
- Redirect (REQ/WAIT/HOLD): pc<=redirect_pc.
  - REQ without gnt: stay in REQ. The new address appears on imem_addr the next cycle.
  - REQ with gnt in the same cycle: -> WAIT with discard=1, because the old-address response must be dropped.
  - WAIT: discard<=1. If rvalid arrives in the same cycle, drop it and -> REQ.
  - HOLD: redirect beats inst_ready. The instruction is dropped with no count increment, inst_valid<=0, -> REQ.
- Minimum latency: start at cycle 0 -> imem_req cycle 1. With gnt in cycle 1 and rvalid in cycle 2, inst_valid rises in cycle 3. Peak throughput is one instruction per 3 cycles.
- imem_rvalid outside WAIT is ignored. Only one request is ever outstanding.

Test Plan:
- Reset, start, memory with gnt same cycle and rvalid next cycle returning rdata=addr+0x100, inst_ready=1 -> inst_pc 0,1,2… with inst 0x100,0x101…; inst_valid every 3rd cycle starting cycle 3; inst_count increments per handshake.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0; release -> count+1, next request at pc+1.
- Redirect to 0x40 during WAIT, with old response arriving 2 cycles later -> old data discarded, next imem_addr=0x40, delivered inst_pc=0x40.
- Redirect in HOLD with inst_ready=1 in the same cycle -> instruction dropped, inst_count unchanged, next request at redirect_pc.
- pc=0xFF fetch -> inst_pc=0xFF, next imem_addr=0x00. Then a halt word (inst[31:26]=6'b111111) accepted -> halted=1, no further imem_req despite start or redirect.
- rst asserted asynchronously in WAIT -> all outputs reset immediately; a late rvalid is ignored in IDLE.

Source files
------------

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// fetch_sequencer: multi-cycle instruction fetch controller that owns the PC,
// keeps one instruction-memory request in flight and hands words to decode.
module fetch_sequencer #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INST_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]          HALT_OPCODE = 6'b111111,
  parameter int                  COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INST_WIDTH-1:0]  imem_rdata,
  output logic                   inst_valid,
  output logic [INST_WIDTH-1:0]  inst,
  output logic [PC_WIDTH-1:0]    inst_pc,
  input  logic                   inst_ready,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] inst_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [PC_WIDTH-1:0] req_pc;
  logic                discard;

  logic inst_is_halt;
  logic granted;
  logic capture;
  logic retire;
  logic take_redirect;

  assign inst_is_halt  = (inst[31:26] == HALT_OPCODE);
  assign granted       = (state == S_REQ) && imem_gnt;
  // A redirect in the same cycle as the response kills it just like a stale one.
  assign capture       = (state == S_WAIT) && imem_rvalid && !discard && !redirect_valid;
  assign retire        = (state == S_HOLD) && inst_ready && !redirect_valid;
  assign take_redirect = redirect_valid && (state != S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          next_state = (discard || redirect_valid) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          next_state = S_REQ;
        end else if (inst_ready) begin
          next_state = inst_is_halt ? S_HALT : S_REQ;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state == S_REQ);
    inst_valid = (state == S_HOLD);
    halted     = (state == S_HALT);
    imem_addr  = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (take_redirect) begin
      pc <= redirect_pc;
    end else if (capture) begin
      pc <= req_pc + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc <= '0;
    end else if (granted) begin
      req_pc <= pc;
    end
  end

  // The in-flight response belongs to an abandoned address once a redirect is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= 1'b0;
    end else if (granted) begin
      discard <= redirect_valid;
    end else if (state == S_WAIT) begin
      if (imem_rvalid) begin
        discard <= 1'b0;
      end else if (redirect_valid) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst    <= '0;
      inst_pc <= '0;
    end else if (capture) begin
      inst    <= imem_rdata;
      inst_pc <= req_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count <= '0;
    end else if (retire) begin
      inst_count <= inst_count + COUNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fetch_sequencer: randomized bench for fetch_sequencer against a
// transaction-level model of the fetch stream and a simple memory responder.
module tb_fetch_sequencer;
  localparam int PW = 8;
  localparam int IW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [PW-1:0] inst_pc;
  logic          inst_ready;
  logic [PW-1:0] pc;
  logic          halted;
  logic [CW-1:0] inst_count;

  fetch_sequencer #(
    .PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(8'h00),
    .HALT_OPCODE(6'b111111), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc(pc), .halted(halted), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // memory responder
  logic [IW-1:0] mem [256];
  logic          mem_busy;
  logic [PW-1:0] mem_addr;
  int            mem_delay;
  int            gnt_pct, rdy_pct, dly_min, dly_max;

  // fetch-stream model
  logic          m_started, m_halted, m_out, m_live, m_hold;
  logic [PW-1:0] m_next, m_out_addr, m_hold_pc;
  logic [IW-1:0] m_hold_inst;
  logic [CW-1:0] m_count;

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_out = 0; m_live = 0; m_hold = 0;
    m_next = 8'h00; m_out_addr = 0; m_hold_pc = 0; m_hold_inst = 0; m_count = 0;
  endtask

  task automatic compare_outputs();
    logic exp_req;
    exp_req = m_started && !m_halted && !m_out && !m_hold;
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_next));
    check("pc", 64'(pc), 64'(m_next));
    check("inst_valid", 64'(inst_valid), 64'(m_hold));
    if (m_hold) begin
      check("inst", 64'(inst), 64'(m_hold_inst));
      check("inst_pc", 64'(inst_pc), 64'(m_hold_pc));
    end
    check("inst_count", 64'(inst_count), 64'(m_count));
    check("halted", 64'(halted), 64'(m_halted));
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input logic st, input logic rv, input logic [PW-1:0] rp);
    logic grant, resp, hs, hdrop, gave_rv;
    logic [PW-1:0] gaddr;
    start = st; redirect_valid = rv; redirect_pc = rp;
    imem_gnt    = imem_req && !mem_busy && ($urandom_range(99) < gnt_pct);
    gave_rv     = mem_busy && (mem_delay == 0);
    imem_rvalid = gave_rv;
    imem_rdata  = mem_busy ? mem[mem_addr] : $urandom;
    inst_ready  = ($urandom_range(99) < rdy_pct);
    gaddr = imem_addr;
    if (!m_halted) begin
      grant = m_started && !m_out && !m_hold && imem_gnt;
      resp  = m_out && imem_rvalid;
      hs    = m_hold && inst_ready && !rv;
      hdrop = m_hold && rv;
      if (st) m_started = 1;
      if (hs) begin
        m_hold = 0;
        m_count = m_count + 1'b1;
        if (m_hold_inst[31:26] == 6'h3F) m_halted = 1;
      end else if (hdrop) begin
        m_hold = 0;
      end
      if (grant) begin
        m_out = 1; m_out_addr = m_next; m_live = !rv;
      end else if (resp) begin
        m_out = 0;
        if (m_live && !rv) begin
          m_hold = 1; m_hold_pc = m_out_addr; m_hold_inst = imem_rdata;
          m_next = m_out_addr + 1'b1;
        end
      end else if (m_out && rv) begin
        m_live = 0;
      end
      if (rv) m_next = rp;
    end
    @(posedge clk); #1;
    if (gave_rv) mem_busy = 0;
    else if (mem_busy) mem_delay--;
    if (imem_gnt) begin
      mem_busy = 1; mem_addr = gaddr; mem_delay = $urandom_range(dly_max, dly_min);
    end
    cyc++;
    compare_outputs();
  endtask

  task automatic do_async_reset();
    #($urandom_range(3, 1));
    rst = 1'b1;
    #1;
    check("arst_req", 64'(imem_req), 64'd0);
    check("arst_valid", 64'(inst_valid), 64'd0);
    check("arst_inst", 64'(inst), 64'd0);
    check("arst_inst_pc", 64'(inst_pc), 64'd0);
    check("arst_pc", 64'(pc), 64'd0);
    check("arst_halted", 64'(halted), 64'd0);
    check("arst_count", 64'(inst_count), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcyc [3];
    int nv, t0, idx;
    logic [IW-1:0] held_inst;
    logic [PW-1:0] held_pc;
    logic [CW-1:0] saved_cnt;
    logic saw_ff, seen40;
    logic [IW-1:0] w;

    rst = 1; start = 0; redirect_valid = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; inst_ready = 0;
    mem_busy = 0; mem_addr = 0; mem_delay = 0;
    for (int a = 0; a < 256; a++) mem[a] = 32'h100 + a;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_count", 64'(inst_count), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst = 0;

    // back-to-back stream: inst_valid on cycles 3, 6, 9 after start
    gnt_pct = 100; rdy_pct = 100; dly_min = 0; dly_max = 0;
    vcyc[0] = -1; vcyc[1] = -1; vcyc[2] = -1; nv = 0;
    t0 = cyc;
    step(1, 0, 0);
    repeat (12) begin
      step(0, 0, 0);
      if (inst_valid && nv < 3) begin vcyc[nv] = cyc - t0; nv++; end
    end
    check("lat_first", 64'(vcyc[0]), 64'd3);
    check("lat_second", 64'(vcyc[1]), 64'd6);
    check("lat_third", 64'(vcyc[2]), 64'd9);

    // decode stall for 5 cycles
    rdy_pct = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) step(0, 0, 0);
    check("stall_hold_reached", 64'(inst_valid), 64'd1);
    held_inst = inst; held_pc = inst_pc; saved_cnt = m_count;
    repeat (5) step(0, 0, 0);
    check("stall_inst", 64'(inst), 64'(held_inst));
    check("stall_inst_pc", 64'(inst_pc), 64'(held_pc));
    check("stall_no_req", 64'(imem_req), 64'd0);
    rdy_pct = 100;
    step(0, 0, 0);
    check("stall_release_cnt", 64'(inst_count), 64'(saved_cnt + 1'b1));
    step(0, 0, 0);
    check("stall_next_addr", 64'(imem_addr), 64'(held_pc + 1'b1));

    // redirect during WAIT, stale response two cycles later
    dly_min = 2; dly_max = 2;
    for (int i = 0; i < 20 && !(m_out && m_live); i++) step(0, 0, 0);
    check("wait_reached", 64'(m_out && m_live), 64'd1);
    step(0, 1, 8'h40);
    seen40 = 0;
    for (int i = 0; i < 20 && !seen40; i++) begin
      step(0, 0, 0);
      if (inst_valid) seen40 = 1;
    end
    check("redir_wait_inst_pc", 64'(inst_pc), 64'h40);

    // redirect beats inst_ready in HOLD
    dly_min = 0; dly_max = 1; rdy_pct = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) step(0, 0, 0);
    saved_cnt = m_count;
    rdy_pct = 100;
    step(0, 1, 8'h80);
    check("hold_redir_cnt", 64'(inst_count), 64'(saved_cnt));
    check("hold_redir_valid", 64'(inst_valid), 64'd0);
    check("hold_redir_addr", 64'(imem_addr), 64'h80);

    // wrap from 0xFF to 0x00, where a halt word sits
    mem[0] = 32'hFC00_0123;
    rdy_pct = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) step(0, 0, 0);
    rdy_pct = 100;
    step(0, 1, 8'hFF);
    saw_ff = 0;
    for (int i = 0; i < 30 && !halted; i++) begin
      step(0, 0, 0);
      if (inst_valid && inst_pc == 8'hFF) saw_ff = 1;
    end
    check("wrap_ff_delivered", 64'(saw_ff), 64'd1);
    check("halt_reached", 64'(halted), 64'd1);
    repeat (6) step(1'b1, 1'b1, 8'($urandom));
    check("halt_no_req", 64'(imem_req), 64'd0);

    // async reset while waiting on memory; the late response must be ignored
    do_async_reset();
    dly_min = 3; dly_max = 3;
    step(1, 0, 0);
    for (int i = 0; i < 20 && !m_out; i++) step(0, 0, 0);
    do_async_reset();
    repeat (6) step(0, 0, 0);
    check("late_rvalid_ignored", 64'(inst_valid), 64'd0);

    // random episodes
    for (int e = 0; e < 25; e++) begin
      for (int a = 0; a < 256; a++) begin
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        mem[a] = w;
      end
      if ($urandom_range(1) == 1) begin
        idx = $urandom_range(255);
        mem[idx][31:26] = 6'h3F;
      end
      gnt_pct = $urandom_range(100, 20);
      rdy_pct = $urandom_range(100, 20);
      dly_min = 0;
      dly_max = $urandom_range(4);
      for (int i = 0; i < 300; i++)
        step($urandom_range(3) == 0, $urandom_range(19) == 0, 8'($urandom));
      do_async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
